// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot occupancy counter: lane state
// encoding, structural limits and the binary-to-BCD helper.
package parking_pkg;

    localparam int MAX_LANES  = 4;
    localparam int MAX_DIGITS = 4;

    typedef enum logic [2:0] {
        LS_IDLE = 3'd0,
        LS_E1   = 3'd1,
        LS_E2   = 3'd2,
        LS_E3   = 3'd3,
        LS_X1   = 3'd4,
        LS_X2   = 3'd5,
        LS_X3   = 3'd6
    } lane_state_e;

    // Shift-and-add-3 conversion; digits beyond MAX_DIGITS are dropped.
    function automatic logic [4*MAX_DIGITS-1:0] bin_to_bcd(input logic [15:0] bin);
        logic [31:0] sr;
        sr = {16'd0, bin};
        for (int i = 0; i < 16; i++) begin
            for (int d = 0; d < MAX_DIGITS; d++) begin
                sr[16+4*d +: 4] = (sr[16+4*d +: 4] >= 4'd5) ? (sr[16+4*d +: 4] + 4'd3)
                                                            : sr[16+4*d +: 4];
            end
            sr = sr << 1;
        end
        return sr[31:16];
    endfunction

endpackage

// File: rtl/parking_lane_fsm.sv
// One entry/exit lane: sensor synchronizers, passage-tracking FSM,
// registered car_in/car_out pulses and the sticky illegal-sequence flag.
module parking_lane_fsm
    import parking_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic clr_flags,
    output logic car_in,
    output logic car_out,
    output logic seq_err
);

    logic        a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [1:0]  ab_s;
    lane_state_e state_q, state_d;
    logic        car_in_q, car_in_d;
    logic        car_out_q, car_out_d;
    logic        seq_err_q, seq_err_d;
    logic        err_set_s;

    // Two-stage synchronizers for the asynchronous photo-sensor inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_s1_q <= 1'b0;
            a_s2_q <= 1'b0;
            b_s1_q <= 1'b0;
            b_s2_q <= 1'b0;
        end else begin
            a_s1_q <= a;
            a_s2_q <= a_s1_q;
            b_s1_q <= b;
            b_s2_q <= b_s1_q;
        end
    end

    assign ab_s = {a_s2_q, b_s2_q};

    // Next-state logic: each state accepts its own value, one step forward,
    // one step back; anything else is a double change and aborts the passage.
    always_comb begin
        state_d   = state_q;
        car_in_d  = 1'b0;
        car_out_d = 1'b0;
        err_set_s = 1'b0;
        case (state_q)
            LS_IDLE: begin
                case (ab_s)
                    2'b00:   state_d = LS_IDLE;
                    2'b10:   state_d = LS_E1;
                    2'b01:   state_d = LS_X1;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_E1: begin
                case (ab_s)
                    2'b10:   state_d = LS_E1;
                    2'b11:   state_d = LS_E2;
                    2'b00:   state_d = LS_IDLE;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_E2: begin
                case (ab_s)
                    2'b11:   state_d = LS_E2;
                    2'b01:   state_d = LS_E3;
                    2'b10:   state_d = LS_E1;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_E3: begin
                case (ab_s)
                    2'b01:   state_d = LS_E3;
                    2'b00:   begin state_d = LS_IDLE; car_in_d = 1'b1; end
                    2'b11:   state_d = LS_E2;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_X1: begin
                case (ab_s)
                    2'b01:   state_d = LS_X1;
                    2'b11:   state_d = LS_X2;
                    2'b00:   state_d = LS_IDLE;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_X2: begin
                case (ab_s)
                    2'b11:   state_d = LS_X2;
                    2'b10:   state_d = LS_X3;
                    2'b01:   state_d = LS_X1;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            LS_X3: begin
                case (ab_s)
                    2'b10:   state_d = LS_X3;
                    2'b00:   begin state_d = LS_IDLE; car_out_d = 1'b1; end
                    2'b11:   state_d = LS_X2;
                    default: begin state_d = LS_IDLE; err_set_s = 1'b1; end
                endcase
            end
            default: begin
                state_d   = LS_IDLE;
                err_set_s = 1'b1;
            end
        endcase
        seq_err_d = err_set_s | (seq_err_q & ~clr_flags);
    end

    // Lane FSM state with its registered pulse and flag outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LS_IDLE;
            car_in_q  <= 1'b0;
            car_out_q <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            car_in_q  <= car_in_d;
            car_out_q <= car_out_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign car_in  = car_in_q;
    assign car_out = car_out_q;
    assign seq_err = seq_err_q;

endmodule

// File: rtl/parking_lot_counter.sv
// Multi-lane parking lot occupancy counter with clamped binary count,
// BCD display value, full/empty status and sticky overflow/underflow flags.
module parking_lot_counter
    import parking_pkg::*;
#(
    parameter  int NUM_LANES = 2,
    parameter  int DIGITS    = 2,
    parameter  int CAPACITY  = 50,
    localparam int W         = $clog2(CAPACITY + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LANES-1:0]  a,
    input  logic [NUM_LANES-1:0]  b,
    input  logic                  clr_flags,
    output logic [W-1:0]          count_bin,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  full,
    output logic                  empty,
    output logic [NUM_LANES-1:0]  car_in,
    output logic [NUM_LANES-1:0]  car_out,
    output logic [NUM_LANES-1:0]  seq_err,
    output logic                  ovf,
    output logic                  unf
);

    localparam logic [W-1:0] CAP_W = W'(CAPACITY);

    logic [W-1:0]        count_bin_q, count_bin_d;
    logic [4*DIGITS-1:0] count_bcd_q, count_bcd_d;
    logic                full_q, full_d;
    logic                empty_q, empty_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                ovf_set_s, unf_set_s;
    int                  n_in_s, n_out_s, next_s;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        parking_lane_fsm u_lane (
            .clk       (clk),
            .reset     (reset),
            .a         (a[g]),
            .b         (b[g]),
            .clr_flags (clr_flags),
            .car_in    (car_in[g]),
            .car_out   (car_out[g]),
            .seq_err   (seq_err[g])
        );
    end

    // Net all lane pulses first, then clamp to the legal occupancy range.
    always_comb begin
        n_in_s    = 0;
        n_out_s   = 0;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n_in_s  = n_in_s + int'(car_in[i]);
            n_out_s = n_out_s + int'(car_out[i]);
        end
        next_s = int'(count_bin_q) + n_in_s - n_out_s;
        if (next_s > CAPACITY) begin
            count_bin_d = CAP_W;
            ovf_set_s   = 1'b1;
        end else if (next_s < 0) begin
            count_bin_d = {W{1'b0}};
            unf_set_s   = 1'b1;
        end else begin
            count_bin_d = W'(next_s);
        end
        full_d      = (count_bin_d == CAP_W);
        empty_d     = (count_bin_d == {W{1'b0}});
        ovf_d       = ovf_set_s | (ovf_q & ~clr_flags);
        unf_d       = unf_set_s | (unf_q & ~clr_flags);
        count_bcd_d = (4*DIGITS)'(bin_to_bcd(16'(count_bin_q)));
    end

    // Occupancy, status and display registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_bin_q <= {W{1'b0}};
            count_bcd_q <= {(4*DIGITS){1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            count_bin_q <= count_bin_d;
            count_bcd_q <= count_bcd_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign count_bin = count_bin_q;
    assign count_bcd = count_bcd_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_parking_lot_counter.sv
// Drives two counter instances (capacity 50 / 2 digits and capacity 999 / 3 digits)
// with shared lane stimulus and checks them against a passage-level model.
module tb_parking_lot_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] sa = 2'b00;
    logic [1:0] sb = 2'b00;
    logic       clr_flags = 1'b0;

    logic [5:0]  p_cnt;
    logic [7:0]  p_bcd;
    logic        p_full, p_empty, p_ovf, p_unf;
    logic [1:0]  p_cin, p_cout, p_serr;
    logic [9:0]  q_cnt;
    logic [11:0] q_bcd;
    logic        q_full, q_empty, q_ovf, q_unf;
    logic [1:0]  q_cin, q_cout, q_serr;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    parking_lot_counter #(.NUM_LANES(2), .DIGITS(2), .CAPACITY(50)) u_p (
        .clk(clk), .reset(reset), .a(sa), .b(sb), .clr_flags(clr_flags),
        .count_bin(p_cnt), .count_bcd(p_bcd), .full(p_full), .empty(p_empty),
        .car_in(p_cin), .car_out(p_cout), .seq_err(p_serr), .ovf(p_ovf), .unf(p_unf)
    );

    parking_lot_counter #(.NUM_LANES(2), .DIGITS(3), .CAPACITY(999)) u_q (
        .clk(clk), .reset(reset), .a(sa), .b(sb), .clr_flags(clr_flags),
        .count_bin(q_cnt), .count_bcd(q_bcd), .full(q_full), .empty(q_empty),
        .car_in(q_cin), .car_out(q_cout), .seq_err(q_serr), .ovf(q_ovf), .unf(q_unf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A lane is described as a direction and a position along its path of
    // sensor values; counts are plain integers clamped to each capacity.
    bit        mvalid = 1'b0;
    int        cap[2] = '{50, 999};
    int        m_cnt[2];
    int        m_bcd[2];
    bit        m_full[2], m_empty[2], m_ovf[2], m_unf[2];
    bit [1:0]  d1[2], d2[2];
    int        dir[2], pos[2];
    bit [1:0]  m_in, m_out, m_err;
    bit [1:0]  ep[4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    bit [1:0]  xp[4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    function automatic int to_bcd(input int c);
        return (c % 10) + ((c / 10) % 10) * 16 + ((c / 100) % 10) * 256;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                mvalid = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    m_cnt[i] = 0; m_bcd[i] = 0; m_full[i] = 1'b0; m_empty[i] = 1'b1;
                    m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
                    d1[i] = 2'b00; d2[i] = 2'b00; dir[i] = 0; pos[i] = 0;
                end
                m_in = 2'b00; m_out = 2'b00; m_err = 2'b00;
            end else begin
                int net;
                net = int'(m_in[0]) + int'(m_in[1]) - int'(m_out[0]) - int'(m_out[1]);
                for (int i = 0; i < 2; i++) begin
                    int nxt;
                    bit os, us;
                    m_bcd[i] = to_bcd(m_cnt[i]);
                    nxt = m_cnt[i] + net;
                    os = (nxt > cap[i]);
                    us = (nxt < 0);
                    m_cnt[i] = os ? cap[i] : (us ? 0 : nxt);
                    m_ovf[i] = os | (m_ovf[i] & !clr_flags);
                    m_unf[i] = us | (m_unf[i] & !clr_flags);
                    m_full[i] = (m_cnt[i] == cap[i]);
                    m_empty[i] = (m_cnt[i] == 0);
                end
                for (int l = 0; l < 2; l++) begin
                    bit [1:0] v, cur, nx, pv;
                    bit set;
                    v = d2[l];
                    set = 1'b0;
                    m_in[l] = 1'b0;
                    m_out[l] = 1'b0;
                    cur = (dir[l] == 0) ? 2'b00 : ((dir[l] == 1) ? ep[pos[l]] : xp[pos[l]]);
                    if (v != cur) begin
                        if (dir[l] == 0) begin
                            if (v == 2'b10) begin dir[l] = 1; pos[l] = 1; end
                            else if (v == 2'b01) begin dir[l] = 2; pos[l] = 1; end
                            else set = 1'b1;
                        end else begin
                            nx = (dir[l] == 1) ? ep[(pos[l] + 1) % 4] : xp[(pos[l] + 1) % 4];
                            pv = (dir[l] == 1) ? ep[pos[l] - 1] : xp[pos[l] - 1];
                            if (v == nx) begin
                                if (pos[l] == 3) begin
                                    if (dir[l] == 1) m_in[l] = 1'b1;
                                    else m_out[l] = 1'b1;
                                    dir[l] = 0; pos[l] = 0;
                                end else begin
                                    pos[l] = pos[l] + 1;
                                end
                            end else if (v == pv) begin
                                pos[l] = pos[l] - 1;
                                if (pos[l] == 0) dir[l] = 0;
                            end else begin
                                set = 1'b1; dir[l] = 0; pos[l] = 0;
                            end
                        end
                    end
                    m_err[l] = set | (m_err[l] & !clr_flags);
                    d2[l] = d1[l];
                    d1[l] = {sa[l], sb[l]};
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (mvalid) begin
                chk("p_count", 32'(p_cnt), 32'(m_cnt[0]));
                chk("p_bcd", 32'(p_bcd), 32'(m_bcd[0]));
                chk("p_full", 32'(p_full), 32'(m_full[0]));
                chk("p_empty", 32'(p_empty), 32'(m_empty[0]));
                chk("p_ovf", 32'(p_ovf), 32'(m_ovf[0]));
                chk("p_unf", 32'(p_unf), 32'(m_unf[0]));
                chk("p_car_in", 32'(p_cin), 32'(m_in));
                chk("p_car_out", 32'(p_cout), 32'(m_out));
                chk("p_seq_err", 32'(p_serr), 32'(m_err));
                chk("q_count", 32'(q_cnt), 32'(m_cnt[1]));
                chk("q_bcd", 32'(q_bcd), 32'(m_bcd[1]));
                chk("q_full", 32'(q_full), 32'(m_full[1]));
                chk("q_empty", 32'(q_empty), 32'(m_empty[1]));
                chk("q_ovf", 32'(q_ovf), 32'(m_ovf[1]));
                chk("q_unf", 32'(q_unf), 32'(m_unf[1]));
                chk("q_car_in", 32'(q_cin), 32'(m_in));
                chk("q_car_out", 32'(q_cout), 32'(m_out));
                chk("q_seq_err", 32'(q_serr), 32'(m_err));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input bit [1:0] v0, input bit [1:0] v1, input int hold);
        sa = {v1[1], v0[1]};
        sb = {v1[0], v0[0]};
        repeat (hold) @(negedge clk);
    endtask

    task automatic entry0(input int h);
        drive(2'b10, 2'b00, h); drive(2'b11, 2'b00, h);
        drive(2'b01, 2'b00, h); drive(2'b00, 2'b00, h);
    endtask

    task automatic exit1(input int h);
        drive(2'b00, 2'b01, h); drive(2'b00, 2'b11, h);
        drive(2'b00, 2'b10, h); drive(2'b00, 2'b00, h);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_count", 32'(q_cnt), 32'd0);
        chk("rst_empty", 32'(q_empty), 32'd1);
        chk("rst_full", 32'(p_full), 32'd0);
        reset = 1'b0;
        drive(2'b00, 2'b00, 5);

        entry0(5);
        repeat (6) @(negedge clk);
        chk("entry_count", 32'(p_cnt), 32'd1);
        chk("entry_bcd", 32'(p_bcd), 32'h01);
        chk("entry_empty", 32'(p_empty), 32'd0);

        exit1(5);
        repeat (6) @(negedge clk);
        chk("exit_count", 32'(p_cnt), 32'd0);
        chk("exit_empty", 32'(p_empty), 32'd1);
        chk("exit_unf", 32'(p_unf), 32'd0);
        exit1(5);
        repeat (6) @(negedge clk);
        chk("exit2_count", 32'(p_cnt), 32'd0);
        chk("exit2_unf", 32'(p_unf), 32'd1);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("clr_unf", 32'(p_unf), 32'd0);

        drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3);
        drive(2'b10, 2'b00, 3); drive(2'b00, 2'b00, 8);
        chk("partial_count", 32'(p_cnt), 32'd0);
        chk("partial_seq_err", 32'(p_serr), 32'd0);

        drive(2'b11, 2'b00, 4);
        chk("illegal_seq_err", 32'(p_serr), 32'd1);
        drive(2'b00, 2'b00, 4);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        chk("clr_seq_err", 32'(p_serr), 32'd0);

        for (int i = 0; i < 50; i++) entry0(2);
        repeat (6) @(negedge clk);
        chk("fill_count", 32'(p_cnt), 32'd50);
        chk("fill_full", 32'(p_full), 32'd1);
        chk("fill_bcd", 32'(p_bcd), 32'h50);

        drive(2'b10, 2'b01, 2); drive(2'b11, 2'b11, 2);
        drive(2'b01, 2'b10, 2); drive(2'b00, 2'b00, 8);
        chk("net_count", 32'(p_cnt), 32'd50);
        chk("net_ovf", 32'(p_ovf), 32'd0);

        entry0(2);
        repeat (6) @(negedge clk);
        chk("over_count", 32'(p_cnt), 32'd50);
        chk("over_ovf", 32'(p_ovf), 32'd1);
        chk("over_q_count", 32'(q_cnt), 32'd51);

        for (int i = 0; i < 72; i++) entry0(2);
        repeat (6) @(negedge clk);
        chk("q_count_123", 32'(q_cnt), 32'd123);
        chk("q_bcd_123", 32'(q_bcd), 32'h123);

        drive(2'b10, 2'b00, 3); drive(2'b11, 2'b00, 3);
        sa = 2'b00; sb = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_count", 32'(q_cnt), 32'd0);
        chk("mid_rst_bcd", 32'(q_bcd), 32'd0);
        chk("mid_rst_empty", 32'(q_empty), 32'd1);
        chk("mid_rst_p_ovf", 32'(p_ovf), 32'd0);
        chk("mid_rst_p_full", 32'(p_full), 32'd0);
        reset = 1'b0;
        drive(2'b00, 2'b00, 8);
        chk("after_rst_count", 32'(q_cnt), 32'd0);
        chk("after_rst_seq_err", 32'(q_serr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/parking_lot_counter.md
PARKING_LOT_COUNTER -- requirements
Module: parking_lot_counter

Interface
REQ-001 Parameter NUM_LANES, default 2: number of independent entry/exit lanes; legal range 1..4.
REQ-002 Parameter DIGITS, default 2: number of BCD digits in the displayed count; legal range 1..4.
REQ-003 Parameter CAPACITY, default 50: maximum occupancy; legal range 1..(10^DIGITS - 1).
REQ-004 Derived width W SHALL be clog2(CAPACITY+1).
REQ-005 clk  in  1  single system clock; all logic SHALL be clocked on the rising edge of clk.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 a  in  NUM_LANES  outer photo-sensor per lane; 1 = beam blocked; asynchronous to clk.
REQ-008 b  in  NUM_LANES  inner photo-sensor per lane; 1 = beam blocked; asynchronous to clk.
REQ-009 clr_flags  in  1  one-cycle request to clear the sticky flags.
REQ-010 count_bin  out  W  current occupancy, binary.
REQ-011 count_bcd  out  4*DIGITS  current occupancy, BCD; digit 0 in bits [3:0]; feeds the display multiplexer.
REQ-012 full  out  1  count_bin == CAPACITY.
REQ-013 empty  out  1  count_bin == 0.
REQ-014 car_in  out  NUM_LANES  one-cycle pulse per completed entry, per lane.
REQ-015 car_out  out  NUM_LANES  one-cycle pulse per completed exit, per lane.
REQ-016 seq_err  out  NUM_LANES  sticky per-lane illegal-sequence flag.
REQ-017 ovf  out  1  sticky flag: an entry was dropped because the lot was full.
REQ-018 unf  out  1  sticky flag: an exit was dropped because the lot was empty.

Function
REQ-019 Each a/b bit SHALL pass through a 2-FF synchronizer; a pin change becomes visible to the lane FSM 2 cycles later.
REQ-020 Lane FSM states, with sensor value {a,b}: IDLE, E1 (10), E2 (11), E3 (01), X1 (01), X2 (11), X3 (10).
REQ-021 Entry path: IDLE-10->E1-11->E2-01->E3-00->IDLE; leaving E3 on 00 SHALL pulse car_in for that lane.
REQ-022 Exit path: IDLE-01->X1-11->X2-10->X3-00->IDLE; leaving X3 on 00 SHALL pulse car_out for that lane.
REQ-023 Back-out: E1/X1 on 00 -> IDLE; E2 -> E1 on 10; E3 -> E2 on 11; X2 -> X1 on 01; X3 -> X2 on 11; none of these SHALL produce a pulse.
REQ-024 Any state SHALL remain unchanged while {a,b} equals its own value.
REQ-025 IDLE on 11, and any other transition not listed above (both bits changing at once), SHALL go to IDLE and set seq_err[lane]; no pulse is produced.
REQ-026 car_in and car_out SHALL be registered and asserted in the cycle the FSM enters IDLE; they SHALL never both be asserted for the same lane.
REQ-027 Each cycle the block SHALL compute next = count_bin + popcount(car_in) - popcount(car_out) and register it one cycle after the pulses.
REQ-028 If next > CAPACITY: count_bin SHALL become CAPACITY and ovf SHALL be set; if next < 0: count_bin SHALL become 0 and unf SHALL be set.
REQ-029 Simultaneous entries and exits on different lanes SHALL net before clamping; e.g. full + 1 in + 1 out leaves count unchanged with no ovf.
REQ-030 full and empty SHALL be registered in the same cycle as count_bin.
REQ-031 count_bcd SHALL be the double-dabble conversion of count_bin, registered one cycle after count_bin.
REQ-032 clr_flags SHALL clear ovf, unf and all seq_err bits; a set condition in the same cycle SHALL win over the clear.

Reset
REQ-033 On reset: all FSMs SHALL go to IDLE; synchronizers, count_bin, count_bcd, car_in, car_out, seq_err, ovf and unf SHALL be 0; empty SHALL be 1 and full SHALL be 0.
REQ-034 A reset in the middle of a sequence SHALL discard the partial passage; a car already between the sensors SHALL NOT be counted.

Structure
REQ-035 Shared package parking_pkg SHALL hold the lane state encoding, the MAX_LANES=4 and MAX_DIGITS=4 constants, and the bin-to-BCD function.
REQ-036 Sub-module parking_lane_fsm SHALL contain one lane's synchronizer, FSM, pulse generation and seq_err; it is instantiated NUM_LANES times.

Verification
REQ-037 Lane 0, {a,b} = 00,10,11,01,00, each held 5 cycles -> one car_in[0] pulse; count_bin 0->1; count_bcd 0x01 one cycle later; empty drops.
REQ-038 Lane 1 exit sequence starting from count 1 -> one car_out[1] pulse; count 0; empty=1; unf=0. The same sequence again -> count stays 0; unf=1.
REQ-039 Partial entry 10,11,10,00 -> no pulses, count unchanged, seq_err=0.
REQ-040 IDLE then 00->11 -> seq_err[0]=1; clr_flags pulse -> seq_err cleared.
REQ-041 CAPACITY=50, count 50, lane 0 entry and lane 1 exit completing in the same cycle -> count stays 50, ovf=0; a lone entry afterwards -> count 50, ovf=1.
REQ-042 DIGITS=3, CAPACITY=999: drive 123 entries -> count_bcd = 0x123; assert reset mid-sequence -> all outputs at their reset values next cycle.
